// File: rtl/dac_pkg.sv
// dac_pkg: state encodings, frame geometry and power-down codes shared by the DAC SPI transmitter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dac_pkg;

  localparam int FRAME_BITS = 16;   // bits per SPI frame on the DAC121S101
  localparam int DAC_CODE_W = 12;   // DAC code width inside the frame

  // Power-down field, frame bits [13:12]
  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } dac_state_t;

  // Frame layout: two don't-care zeros, power-down bits, 12-bit code.
  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [1:0]            pd,
                                                       input logic [DAC_CODE_W-1:0] code);
    return {2'b00, pd, code};
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// dac_sclk_gen: SPI clock generator; phase counter of 2*CLK_DIV clk cycles per bit period.
// Latency: sclk is registered; strobes are combinational and mark the edge where sclk falls/rises next.
// Backpressure: none; runs only while en is high, otherwise holds phase 0 and sclk high.
//
// Ports:
//   clk, reset_n   clock and async active-low reset
//   en             high while the transmitter is shifting
//   fall_stb       next clk edge drives sclk low (DAC sampling edge)
//   rise_stb       next clk edge ends the bit period and drives sclk high
//   sclk           registered SPI clock, idles high
module dac_sclk_gen
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic fall_stb,
  output logic rise_stb,
  output logic sclk
);

  localparam int PER = 2 * CLK_DIV;
  localparam int CW  = $clog2(PER);

  logic [CW-1:0] ph_q;
  logic [CW-1:0] ph_d;

  // Phase 0..CLK_DIV-1 is the high half, CLK_DIV..PER-1 the low half.
  always_comb begin
    ph_d = '0;
    if (en && (ph_q != CW'(PER - 1))) begin
      ph_d = ph_q + CW'(1);
    end
  end

  assign fall_stb = en && (ph_q == CW'(CLK_DIV - 1));
  assign rise_stb = en && (ph_q == CW'(PER - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q <= '0;
      sclk <= 1'b1;
    end else begin
      ph_q <= ph_d;
      // ph_d is 0 whenever en is low, so sclk parks high outside a frame.
      sclk <= (ph_d < CW'(CLK_DIV));
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises one sample per valid/ready handshake into a 16-bit SPI frame for a DAC121S101.
// Latency: sync_n falls on the accepting edge; frame_done 34*CLK_DIV-1 edges later; ready one edge after that.
// Backpressure: sample_ready low for the whole frame and gap; valid while not ready is ignored, never queued.
//
// Ports:
//   clk, reset_n          10 MHz clock, async active-low reset
//   sample[DATA_W]        sample, left-justified into the 12-bit DAC code
//   pd_mode[2]            DAC power-down bits, 00 = normal operation
//   sample_valid/ready    handshake; transfer when both high at a clk edge
//   busy                  frame or inter-frame gap in progress
//   frame_done            one-cycle pulse in the last gap cycle
//   dac_sclk/sync_n/sdata SPI outputs; sclk idles high, data MSB first
//
// Build option: define DAC_SIGNED_EN to treat sample as two's complement
// (MSB inverted to offset binary before packing); undefined = unsigned.
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample,
  input  logic [1:0]        pd_mode,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              dac_sclk,
  output logic              dac_sync_n,
  output logic              dac_sdata
);

  localparam int BIT_W    = $clog2(FRAME_BITS);
  localparam int GAP_W    = $clog2(2 * CLK_DIV);
  localparam int GAP_LAST = 2 * CLK_DIV - 1;

  // ---------------------------------------------------------------------------
  // Frame packing
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]     samp_x;
  logic [DAC_CODE_W-1:0] code;
  logic [FRAME_BITS-1:0] frame_in;

`ifdef DAC_SIGNED_EN
  // Two's complement to offset binary: flip the sign bit only.
  assign samp_x = sample ^ (DATA_W'(1) << (DATA_W - 1));
`else
  assign samp_x = sample;
`endif

  assign code     = DAC_CODE_W'(samp_x) << (DAC_CODE_W - DATA_W);
  assign frame_in = pack_frame(pd_mode, code);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  dac_state_t            state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]      bit_q,   bit_d;
  logic [GAP_W-1:0]      gap_q,   gap_d;
  logic                  ready_q, ready_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic                  sync_q,  sync_d;
  logic                  sdata_q, sdata_d;

  logic                  fall_stb;
  logic                  rise_stb;

  dac_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (state_q == ST_SHIFT),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb),
    .sclk     (dac_sclk)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sync_d  = sync_q;
    sdata_d = sdata_q;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        sync_d  = 1'b1;
        sdata_d = 1'b0;
        if (sample_valid && ready_q) begin
          // First bit goes out on the accepting edge, with sclk still high.
          state_d = ST_SHIFT;
          shreg_d = frame_in;
          bit_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          sync_d  = 1'b0;
          sdata_d = frame_in[FRAME_BITS-1];
        end
      end

      ST_SHIFT: begin
        // Pre-shift on the falling edge so the next bit sits at the MSB
        // ready to be presented together with the following rising edge.
        if (fall_stb) begin
          shreg_d = shreg_q << 1;
        end
        if (rise_stb) begin
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            state_d = ST_GAP;
            gap_d   = '0;
            sync_d  = 1'b1;
            sdata_d = 1'b0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            sdata_d = shreg_q[FRAME_BITS-1];
          end
        end
      end

      ST_GAP: begin
        // sync_n stays high for 2*CLK_DIV cycles so the DAC sees its minimum
        // sync-high time before the next frame.
        if (gap_q == GAP_W'(GAP_LAST)) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          gap_d  = gap_q + GAP_W'(1);
          done_d = (gap_q == GAP_W'(GAP_LAST - 1));
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        sync_d  = 1'b1;
        sdata_d = 1'b0;
      end
    endcase
  end

  // Asynchronous reset aborts a frame at once; sync_n rising early makes the
  // DAC discard the partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sync_q  <= 1'b1;
      sdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sync_q  <= sync_d;
      sdata_q <= sdata_d;
    end
  end

  assign sample_ready = ready_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign dac_sync_n   = sync_q;
  assign dac_sdata    = sdata_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed, table-driven bench for dac_spi_tx (CLK_DIV=2 main instance,
// plus CLK_DIV=1 and CLK_DIV=4 instances for clock-ratio checks).
// Cycle numbering: cyc counts posedges; N is the cyc value when valid is driven.
module tb_dac_spi_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] sample = 8'h00;
  logic [1:0] pd_mode = 2'b00;
  logic       valid = 1'b0;
  logic       valid_x = 1'b0;
  logic       ready, busy, frame_done, sclk, sync_n, sdata;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_spi_tx #(.DATA_W(8), .CLK_DIV(2)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample       (sample),
    .pd_mode      (pd_mode),
    .sample_valid (valid),
    .sample_ready (ready),
    .busy         (busy),
    .frame_done   (frame_done),
    .dac_sclk     (sclk),
    .dac_sync_n   (sync_n),
    .dac_sdata    (sdata)
  );

  // Main-instance monitor: behaves as the DAC, shifting sdata in on sclk falls.
  logic        m_psclk = 1'b1, m_psync = 1'b1;
  logic [15:0] m_cap = '0;
  int          m_len = 0, m_nb = 0;
  logic [15:0] q_frame[$];
  int          q_len[$], q_nb[$], q_fall[$], q_done[$];

  always @(negedge clk) begin
    if (!sync_n) begin
      if (m_psync) begin
        m_len = 0; m_nb = 0; m_cap = '0;
        q_fall.push_back(cyc);
      end
      m_len++;
      if (m_psclk && !sclk) begin
        m_cap = {m_cap[14:0], sdata};
        m_nb++;
      end
    end else if (!m_psync) begin
      q_frame.push_back(m_cap);
      q_len.push_back(m_len);
      q_nb.push_back(m_nb);
    end
    if (frame_done) q_done.push_back(cyc);
    m_psclk = sclk;
    m_psync = sync_n;
  end

  // Extra instances with other clock ratios, each with its own monitor.
  for (genvar g = 0; g < 2; g++) begin : g_div
    localparam int D = (g == 0) ? 1 : 4;
    logic        x_sclk, x_sync, x_sdata, rdy, x_busy, x_done;
    logic        p_sclk = 1'b1, p_sync = 1'b1;
    logic [15:0] cap = '0;
    int          sync_len = 0, per = 0, last_fall = -1;

    dac_spi_tx #(.DATA_W(8), .CLK_DIV(D)) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample       (sample),
      .pd_mode      (pd_mode),
      .sample_valid (valid_x),
      .sample_ready (rdy),
      .busy         (x_busy),
      .frame_done   (x_done),
      .dac_sclk     (x_sclk),
      .dac_sync_n   (x_sync),
      .dac_sdata    (x_sdata)
    );

    always @(negedge clk) begin
      if (!x_sync) begin
        if (p_sync) begin sync_len = 0; cap = '0; last_fall = -1; end
        sync_len++;
        if (p_sclk && !x_sclk) begin
          cap = {cap[14:0], x_sdata};
          if (last_fall >= 0) per = cyc - last_fall;
          last_fall = cyc;
        end
      end
      p_sclk = x_sclk;
      p_sync = x_sync;
    end
  end

  typedef struct {
    logic [7:0]  s;
    logic [1:0]  pd;
    logic [15:0] exp_u;   // unsigned packing
    logic [15:0] exp_s;   // offset-binary packing
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] model(input logic [7:0] s, input logic [1:0] pd);
    logic [7:0] v;
    v = s;
`ifdef DAC_SIGNED_EN
    v = s ^ 8'h80;
`endif
    return {2'b00, pd, v, 4'h0};
  endfunction

  task automatic q_clear();
    q_frame.delete(); q_len.delete(); q_nb.delete(); q_fall.delete(); q_done.delete();
  endtask

  function automatic logic [15:0] fr_at(input int i);
    return (q_frame.size() > i) ? q_frame[i] : 16'hxxxx;
  endfunction

  function automatic int iq_at(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1000;
  endfunction

  // One-cycle valid; sample/pd are scrambled right after the accepting edge.
  task automatic send(input logic [7:0] s, input logic [1:0] pd, output int acc);
    int t = 0;
    while (!ready && t < 300) begin tick(); t++; end
    check("send_ready", ready, 1);
    sample = s; pd_mode = pd; valid = 1'b1; acc = cyc;
    tick();
    valid = 1'b0; sample = ~s; pd_mode = ~pd;
  endtask

  task automatic run_frame(input string nm, input logic [7:0] s, input logic [1:0] pd,
                           input logic [15:0] exp);
    int acc;
    int t = 0;
    q_clear();
    send(s, pd, acc);
    check({nm, "_ready_drop"}, ready, 0);
    check({nm, "_sync_start"}, sync_n, 0);
    check({nm, "_busy"}, busy, 1);
    while (!ready && t < 300) begin tick(); t++; end
    check({nm, "_ready_cyc"}, cyc - acc, 69);
    check({nm, "_nframes"}, q_frame.size(), 1);
    check({nm, "_frame"}, fr_at(0), exp);
    check({nm, "_sync_len"}, iq_at(q_len, 0), 64);
    check({nm, "_nbits"}, iq_at(q_nb, 0), 16);
    check({nm, "_sync_fall"}, iq_at(q_fall, 0) - acc, 1);
    check({nm, "_ndone"}, q_done.size(), 1);
    check({nm, "_done_cyc"}, iq_at(q_done, 0) - acc, 68);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc2, t;
    logic [15:0] exp;

    vecs[0] = '{8'hA5, 2'b00, 16'h0A50, 16'h0250};
    vecs[1] = '{8'h01, 2'b00, 16'h0010, 16'h0810};
    vecs[2] = '{8'hFF, 2'b11, 16'h3FF0, 16'h37F0};
    vecs[3] = '{8'h3C, 2'b10, 16'h23C0, 16'h2BC0};
    vecs[4] = '{8'h80, 2'b11, 16'h3800, 16'h3000};
    vecs[5] = '{8'h7F, 2'b00, 16'h07F0, 16'h0FF0};
    vecs[6] = '{8'h00, 2'b01, 16'h1000, 16'h1800};

    // Reset values, checked while reset is held
    #1 reset_n = 1'b0;
    #1;
    check("rst_sclk", sclk, 1);
    check("rst_sync", sync_n, 1);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_sdata", sdata, 0);
    repeat (3) tick();
    reset_n = 1'b1;

    // Idle with no valid: outputs stay at rest
    repeat (20) tick();
    check("idle_sclk", sclk, 1);
    check("idle_sync", sync_n, 1);
    check("idle_ready", ready, 1);
    check("idle_busy", busy, 0);
    check("idle_done", frame_done, 0);
    check("idle_sdata", sdata, 0);

    // Table of single frames
    for (int i = 0; i < 7; i++) begin
      exp = vecs[i].exp_u;
`ifdef DAC_SIGNED_EN
      exp = vecs[i].exp_s;
`endif
      run_frame($sformatf("vec%0d", i), vecs[i].s, vecs[i].pd, exp);
    end

    // Back-to-back with valid held high
    q_clear();
    tick();
    check("b2b_ready0", ready, 1);
    sample = 8'h01; pd_mode = 2'b00; valid = 1'b1; acc1 = cyc;
    tick();
    check("b2b_acc1", ready, 0);
    sample = 8'hFF;
    t = 0;
    while (!ready && t < 300) begin tick(); t++; end
    acc2 = cyc;
    check("b2b_period", acc2 - acc1, 69);
    tick();
    check("b2b_acc2", ready, 0);
    valid = 1'b0; sample = 8'h00;
    t = 0;
    while (!ready && t < 300) begin tick(); t++; end
    check("b2b_nframes", q_frame.size(), 2);
    check("b2b_frame0", fr_at(0), model(8'h01, 2'b00));
    check("b2b_frame1", fr_at(1), model(8'hFF, 2'b00));
    check("b2b_fall_gap", iq_at(q_fall, 1) - iq_at(q_fall, 0), 69);
    check("b2b_ndone", q_done.size(), 2);

    // Reset in the middle of a frame
    q_clear();
    send(8'h55, 2'b00, acc);
    t = 0;
    while (cyc < acc + 20 && t < 100) begin tick(); t++; end
    check("mid_sync_low", sync_n, 0);
    check("mid_sclk_low", sclk, 0);
    reset_n = 1'b0;
    #1;
    check("abort_sync", sync_n, 1);
    check("abort_sclk", sclk, 1);
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_sdata", sdata, 0);
    tick();
    reset_n = 1'b1;
    tick();
    run_frame("recover", 8'h3C, 2'b00, model(8'h3C, 2'b00));

    // Other clock ratios
    check("div_ready", g_div[0].rdy & g_div[1].rdy, 1);
    sample = 8'hA5; pd_mode = 2'b00; valid_x = 1'b1;
    tick();
    valid_x = 1'b0;
    t = 0;
    while (!(g_div[0].rdy && g_div[1].rdy) && t < 400) begin tick(); t++; end
    check("div1_frame", g_div[0].cap, model(8'hA5, 2'b00));
    check("div1_sync_len", g_div[0].sync_len, 32);
    check("div1_sclk_per", g_div[0].per, 2);
    check("div4_frame", g_div[1].cap, model(8'hA5, 2'b00));
    check("div4_sync_len", g_div[1].sync_len, 128);
    check("div4_sclk_per", g_div[1].per, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
